// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer.
// FSM state encoding and counter sizing helper.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_ASSERT_RST = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_QUALIFY    = 3'd2,
    S_RELEASE    = 3'd3,
    S_RUN        = 3'd4,
    S_LOSS       = 3'd5,
    S_FAULT      = 3'd6
  } state_t;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Sequencer-facing bundle: PLL status in, reset controls out.
// PLL_SEQ_LOSS_COUNT_EN adds the lock_loss_cnt field.
interface pll_lock_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3
);

  logic                   locked;
  logic                   relock_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   ready;
  logic                   fault;
  logic [1:0]             retry_cnt;
  logic [STATE_W-1:0]     state_dbg;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0]             lock_loss_cnt;
`endif

  modport master (
    input  locked,
    input  relock_req,
    output pll_rst,
    output domain_rst,
    output ready,
    output fault,
    output retry_cnt,
`ifdef PLL_SEQ_LOSS_COUNT_EN
    output lock_loss_cnt,
`endif
    output state_dbg
  );

  modport slave (
    output locked,
    output relock_req,
    input  pll_rst,
    input  domain_rst,
    input  ready,
    input  fault,
    input  retry_cnt,
`ifdef PLL_SEQ_LOSS_COUNT_EN
    input  lock_loss_cnt,
`endif
    input  state_dbg
  );

endinterface

// File: rtl/pll_seq_sync2.sv
// Two-flop synchronizer bringing PLL locked
// into the refclk domain.
module pll_seq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset pulse, lock qualify, staged release.
// Define PLL_SEQ_LOSS_COUNT_EN to add the lock loss counter.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 50,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int REL_GAP_CYC      = 16,
  parameter int MAX_RETRIES      = 3,
  parameter int NUM_DOMAINS      = 3
) (
  input logic                  refclk,
  input logic                  rst,
  pll_lock_sequencer_if.master io
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC,
                                   LOCK_STABLE_CYC, REL_GAP_CYC);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(REL_GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [1:0]       RTY_LAST = 2'(MAX_RETRIES - 1);
  localparam logic [NUM_DOMAINS-1:0] ALL_RST = '1;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nx;
  logic                   lk;
  logic                   pll_rst_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   ready_q;
  logic                   fault_q;
  logic [1:0]             retry_q;

  pll_seq_sync2 u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (io.locked),
    .q   (lk)
  );

  assign idx_nx = idx + 1'b1;

  // sequencer FSM with registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_ASSERT_RST;
      cnt       <= '0;
      idx       <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= ALL_RST;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retry_q   <= 2'd0;
    end else if (io.relock_req) begin
      state     <= S_ASSERT_RST;
      cnt       <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= ALL_RST;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retry_q   <= 2'd0;
    end else begin
      unique case (state)
        S_ASSERT_RST: begin
          if (cnt == RST_LAST) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            state <= S_QUALIFY;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q == RTY_LAST) begin
              state   <= S_FAULT;
              fault_q <= 1'b1;
              dom_q   <= ALL_RST;
            end else begin
              state   <= S_ASSERT_RST;
              retry_q <= retry_q + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_QUALIFY: begin
          if (!lk) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state    <= S_RELEASE;
            cnt      <= '0;
            idx      <= '0;
            dom_q[0] <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!lk) begin
            state   <= S_LOSS;
            cnt     <= '0;
            dom_q   <= ALL_RST;
            ready_q <= 1'b0;
          end else if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state   <= S_RUN;
              ready_q <= 1'b1;
              retry_q <= 2'd0;
            end else begin
              idx           <= idx_nx;
              dom_q[idx_nx] <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          retry_q <= 2'd0;
          if (!lk) begin
            state   <= S_LOSS;
            cnt     <= '0;
            dom_q   <= ALL_RST;
            ready_q <= 1'b0;
          end
        end
        S_LOSS: begin
          state     <= S_ASSERT_RST;
          cnt       <= '0;
          pll_rst_q <= 1'b1;
        end
        S_FAULT: begin
          pll_rst_q <= 1'b1;
          dom_q     <= ALL_RST;
          ready_q   <= 1'b0;
        end
        default: begin
          state     <= S_ASSERT_RST;
          cnt       <= '0;
          pll_rst_q <= 1'b1;
          dom_q     <= ALL_RST;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_q;
  logic       loss_entry;

  assign loss_entry = !io.relock_req && !lk &&
                      (state == S_RELEASE || state == S_RUN);

  // saturating count of lock losses, cleared only by rst
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else if (loss_entry && loss_q != 8'hff) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign io.lock_loss_cnt = loss_q;
`endif

  assign io.pll_rst    = pll_rst_q;
  assign io.domain_rst = dom_q;
  assign io.ready      = ready_q;
  assign io.fault      = fault_q;
  assign io.retry_cnt  = retry_q;
  assign io.state_dbg  = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: random lock timing
// checked against an event-time model of the sequence.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int RST_P = 5;
  localparam int TO    = 120;
  localparam int STB   = 40;
  localparam int GAP   = 4;
  localparam int MR    = 3;
  localparam int ND    = 3;
  localparam int LIMIT = 2000;
  localparam logic [ND-1:0] ALL = '1;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   lock_rise = 0;

  pll_lock_sequencer_if #(.NUM_DOMAINS(ND)) io ();

  pll_lock_sequencer #(
    .RST_PULSE_CYC    (RST_P),
    .LOCK_TIMEOUT_CYC (TO),
    .LOCK_STABLE_CYC  (STB),
    .REL_GAP_CYC      (GAP),
    .MAX_RETRIES      (MR),
    .NUM_DOMAINS      (ND)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .io     (io)
  );

  always #5 refclk = ~refclk;

  // inputs change and outputs are read 1 time unit after each edge
  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  // release starts STB cycles after qualification begins; qualification
  // begins one cycle after WAIT_LOCK is entered or after locked is seen
  // through the two synchronizer flops, whichever is later
  function automatic int exp_release(input int wl, input int lr);
    int qs;
    qs = (wl + 1 > lr + 3) ? wl + 1 : lr + 3;
    return qs + STB;
  endfunction

  task automatic count_high(output int n);
    n = 0;
    while (io.pll_rst === 1'b1 && n < LIMIT) begin
      n++;
      tick();
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (io.pll_rst === 1'b0 && n < LIMIT) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_dom(input logic [ND-1:0] v, output int at);
    at = -1;
    for (int i = 0; i < LIMIT; i++) begin
      if (io.domain_rst === v) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_ready(output int at);
    at = -1;
    for (int i = 0; i < LIMIT; i++) begin
      if (io.ready === 1'b1) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.relock_req = 1'b1;
    io.locked = 1'($urandom_range(0, 1));
    repeat (3) tick();
    tests++;
    if (io.state_dbg !== 3'd0 || io.pll_rst !== 1'b1 ||
        io.domain_rst !== ALL || io.ready !== 1'b0 ||
        io.fault !== 1'b0 || io.retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL reset_vals: st=%0d prst=%b dom=%b rdy=%b flt=%b rty=%0d want 0 1 111 0 0 0",
               io.state_dbg, io.pll_rst, io.domain_rst, io.ready,
               io.fault, io.retry_cnt);
    end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    tests++;
    if (io.lock_loss_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_loss_cnt: got %0d want 0", io.lock_loss_cnt);
    end
`endif
    io.relock_req = 1'b0;
    io.locked = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_bringup();
    int n, w, d, rel, at;
    logic [ND-1:0] ev;
    count_high(n);
    tests++;
    if (n !== RST_P) begin
      fails++;
      $display("FAIL bringup_pulse: got %0d want %0d", n, RST_P);
    end
    w = cyc;
    d = $urandom_range(0, 20);
    repeat (d) tick();
    io.locked = 1'b1;
    lock_rise = cyc;
    rel = exp_release(w, lock_rise);
    for (int i = 0; i < ND; i++) begin
      ev = ALL << (i + 1);
      wait_dom(ev, at);
      tests++;
      if (at !== rel + i * GAP) begin
        fails++;
        $display("FAIL bringup_dom%0d: got cycle %0d want %0d", i, at, rel + i * GAP);
      end
    end
    wait_ready(at);
    tests++;
    if (at !== rel + ND * GAP || io.state_dbg !== 3'd4 ||
        io.retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL bringup_ready: cycle %0d st=%0d rty=%0d want %0d 4 0",
               at, io.state_dbg, io.retry_cnt, rel + ND * GAP);
    end
  endtask

  task automatic test_timeout();
    int n;
    rst = 1'b1;
    io.locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < MR; a++) begin
      count_high(n);
      tests++;
      if (n !== RST_P) begin
        fails++;
        $display("FAIL timeout_pulse%0d: got %0d want %0d", a, n, RST_P);
      end
      count_low(n);
      tests++;
      if (n !== TO) begin
        fails++;
        $display("FAIL timeout_wait%0d: got %0d want %0d", a, n, TO);
      end
      tests++;
      if (a < MR - 1) begin
        if (io.retry_cnt !== 2'(a + 1) || io.state_dbg !== 3'd0 ||
            io.fault !== 1'b0) begin
          fails++;
          $display("FAIL timeout_retry%0d: rty=%0d st=%0d flt=%b want %0d 0 0",
                   a, io.retry_cnt, io.state_dbg, io.fault, a + 1);
        end
      end else begin
        if (io.fault !== 1'b1 || io.pll_rst !== 1'b1 ||
            io.state_dbg !== 3'd6 || io.domain_rst !== ALL ||
            io.retry_cnt !== 2'(MR - 1)) begin
          fails++;
          $display("FAIL timeout_fault: flt=%b prst=%b st=%0d dom=%b rty=%0d want 1 1 6 111 %0d",
                   io.fault, io.pll_rst, io.state_dbg, io.domain_rst,
                   io.retry_cnt, MR - 1);
        end
      end
    end
    repeat ($urandom_range(3, 30)) tick();
    tests++;
    if (io.fault !== 1'b1 || io.state_dbg !== 3'd6) begin
      fault_msg();
    end
    io.relock_req = 1'b1;
    tick();
    io.relock_req = 1'b0;
    tests++;
    if (io.fault !== 1'b0 || io.state_dbg !== 3'd0 ||
        io.pll_rst !== 1'b1 || io.retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL fault_exit: flt=%b st=%0d prst=%b rty=%0d want 0 0 1 0",
               io.fault, io.state_dbg, io.pll_rst, io.retry_cnt);
    end
  endtask

  task automatic fault_msg();
    fails++;
    $display("FAIL fault_hold: flt=%b st=%0d want 1 6", io.fault, io.state_dbg);
  endtask

  task automatic test_glitch();
    int n, w, d, qs, g, rel, at;
    count_high(n);
    tests++;
    if (n !== RST_P) begin
      fails++;
      $display("FAIL glitch_pulse: got %0d want %0d", n, RST_P);
    end
    w = cyc;
    d = $urandom_range(0, 20);
    repeat (d) tick();
    io.locked = 1'b1;
    lock_rise = cyc;
    qs = exp_release(w, lock_rise) - STB;
    g = $urandom_range(1, STB - 5);
    repeat (qs + g - cyc) tick();
    io.locked = 1'b0;
    tick();
    io.locked = 1'b1;
    lock_rise = cyc;
    rel = exp_release(w, lock_rise);
    wait_dom(ALL << 1, at);
    tests++;
    if (at !== rel || io.retry_cnt !== 2'd0 || io.pll_rst !== 1'b0) begin
      fails++;
      $display("FAIL glitch_requalify: cycle %0d rty=%0d prst=%b want %0d 0 0",
               at, io.retry_cnt, io.pll_rst, rel);
    end
    wait_ready(at);
    tests++;
    if (at !== rel + ND * GAP) begin
      fails++;
      $display("FAIL glitch_ready: got cycle %0d want %0d", at, rel + ND * GAP);
    end
  endtask

  task automatic test_loss();
    int n, w, d, rel, at;
    repeat ($urandom_range(1, 20)) tick();
    io.locked = 1'b0;
    tick();
    tick();
    tests++;
    if (io.ready !== 1'b1 || io.domain_rst !== '0) begin
      fails++;
      $display("FAIL loss_early: rdy=%b dom=%b want 1 000", io.ready, io.domain_rst);
    end
    tick();
    tests++;
    if (io.domain_rst !== ALL || io.ready !== 1'b0 || io.state_dbg !== 3'd5) begin
      fails++;
      $display("FAIL loss_react: dom=%b rdy=%b st=%0d want 111 0 5",
               io.domain_rst, io.ready, io.state_dbg);
    end
    tick();
    tests++;
    if (io.state_dbg !== 3'd0 || io.pll_rst !== 1'b1 || io.retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL loss_restart: st=%0d prst=%b rty=%0d want 0 1 0",
               io.state_dbg, io.pll_rst, io.retry_cnt);
    end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    tests++;
    if (io.lock_loss_cnt !== 8'd1) begin
      fails++;
      $display("FAIL loss_count: got %0d want 1", io.lock_loss_cnt);
    end
`endif
    count_high(n);
    tests++;
    if (n !== RST_P) begin
      fails++;
      $display("FAIL loss_pulse: got %0d want %0d", n, RST_P);
    end
    w = cyc;
    d = $urandom_range(0, 20);
    repeat (d) tick();
    io.locked = 1'b1;
    lock_rise = cyc;
    rel = exp_release(w, lock_rise);
    wait_ready(at);
    tests++;
    if (at !== rel + ND * GAP) begin
      fails++;
      $display("FAIL loss_reseq: got cycle %0d want %0d", at, rel + ND * GAP);
    end
  endtask

  task automatic test_relock_release();
    int n, w, rel, at;
    logic [ND-1:0] ev;
    io.relock_req = 1'b1;
    tick();
    io.relock_req = 1'b0;
    tests++;
    if (io.state_dbg !== 3'd0 || io.domain_rst !== ALL || io.ready !== 1'b0) begin
      fails++;
      $display("FAIL relock_run: st=%0d dom=%b rdy=%b want 0 111 0",
               io.state_dbg, io.domain_rst, io.ready);
    end
    count_high(n);
    w = cyc;
    rel = exp_release(w, lock_rise);
    ev = ALL << 2;
    wait_dom(ev, at);
    tests++;
    if (at !== rel + GAP) begin
      fails++;
      $display("FAIL relock_idx1: got cycle %0d want %0d", at, rel + GAP);
    end
    io.relock_req = 1'b1;
    tick();
    io.relock_req = 1'b0;
    tests++;
    if (io.domain_rst !== ALL || io.state_dbg !== 3'd0 ||
        io.pll_rst !== 1'b1 || io.ready !== 1'b0 || io.retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL relock_release: dom=%b st=%0d prst=%b rdy=%b rty=%0d want 111 0 1 0 0",
               io.domain_rst, io.state_dbg, io.pll_rst, io.ready, io.retry_cnt);
    end
  endtask

  task automatic test_rst_run();
    int n, w, rel, at;
    count_high(n);
    w = cyc;
    rel = exp_release(w, lock_rise);
    wait_ready(at);
    tests++;
    if (at !== rel + ND * GAP) begin
      fails++;
      $display("FAIL rstrun_ready: got cycle %0d want %0d", at, rel + ND * GAP);
    end
    rst = 1'b1;
    io.relock_req = 1'b1;
    tick();
    tests++;
    if (io.state_dbg !== 3'd0 || io.pll_rst !== 1'b1 ||
        io.domain_rst !== ALL || io.ready !== 1'b0 ||
        io.fault !== 1'b0 || io.retry_cnt !== 2'd0) begin
      fails++;
      $display("FAIL rstrun_vals: st=%0d prst=%b dom=%b rdy=%b flt=%b rty=%0d want 0 1 111 0 0 0",
               io.state_dbg, io.pll_rst, io.domain_rst, io.ready,
               io.fault, io.retry_cnt);
    end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    tests++;
    if (io.lock_loss_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rstrun_loss_cnt: got %0d want 0", io.lock_loss_cnt);
    end
`endif
    rst = 1'b0;
    io.relock_req = 1'b0;
  endtask

  initial begin
    io.locked = 1'b0;
    io.relock_req = 1'b0;
    test_reset();
    test_bringup();
    test_timeout();
    test_glitch();
    test_loss();
    test_relock_release();
    test_rst_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
